// File: rtl/busy_gnt_arbiter_pkg.sv
// busy_gnt_arb_pkg: shared state type, default parameters and index-width helper
// Used by busy_gnt_arbiter, its interface and the rr_pick selector.
package busy_gnt_arb_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_BUSY, GRANT} state_t;
    localparam int N_REQ_DEF       = 4;
    localparam int BUSY_CNT_DEF    = 3;
    localparam int TIMEOUT_CYC_DEF = 16;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/busy_gnt_arbiter_if.sv
// busy_gnt_arbiter_if: requester/resource bundle for busy_gnt_arbiter
// req[N_REQ], busy      : driven by the requester/resource side
// gnt[N_REQ], gnt_id, active : driven by the arbiter
// timeout_err           : arbiter abort pulse, present only with BUSY_GNT_ARB_TIMEOUT_EN
interface busy_gnt_arbiter_if
    import busy_gnt_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF
);
    localparam int IDW = idx_w(N_REQ);
    logic [N_REQ-1:0] req;
    logic             busy;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_id;
    logic             active;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
    logic             timeout_err;
    modport master (output req, busy, input gnt, gnt_id, active, timeout_err);
    modport slave  (input req, busy, output gnt, gnt_id, active, timeout_err);
`else
    modport master (output req, busy, input gnt, gnt_id, active);
    modport slave  (input req, busy, output gnt, gnt_id, active);
`endif
endinterface

// File: rtl/busy_gnt_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector
// req[N_REQ] : pending requests
// ptr        : last owner; search starts at ptr+1 and wraps
// valid      : any request pending
// idx        : winning requester index
module rr_pick
    import busy_gnt_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int IDW = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic             valid,
    output logic [IDW-1:0]   idx
);
    // Scan from farthest to nearest so the nearest candidate after ptr wins.
    always_comb begin
        valid = |req;
        idx = '0;
        for (int i = N_REQ; i >= 1; i--)
            if (req[IDW'((int'(ptr) + i) % N_REQ)]) idx = IDW'((int'(ptr) + i) % N_REQ);
    end
endmodule

// File: rtl/busy_gnt_arbiter.sv
// busy_gnt_arbiter: round-robin owner of a busy-signalling resource, grants after BUSY_CNT busy samples
// clk   : rising-edge clock
// rst_n : asynchronous active-low reset
// bus   : busy_gnt_arbiter_if.slave (req, busy in; gnt, gnt_id, active, timeout_err out)
// Optional: define BUSY_GNT_ARB_TIMEOUT_EN to abort WAIT_BUSY after TIMEOUT_CYC busy-free cycles.
module busy_gnt_arbiter
    import busy_gnt_arb_pkg::*;
#(
    parameter int N_REQ    = N_REQ_DEF,
    parameter int BUSY_CNT = BUSY_CNT_DEF
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
) (
    input logic               clk,
    input logic               rst_n,
    busy_gnt_arbiter_if.slave bus
);
    localparam int IDW = idx_w(N_REQ);
    localparam int CW  = $clog2(BUSY_CNT + 1);
    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] pick_idx;
    logic           pick_valid;
    logic [CW-1:0]  cnt;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0]  tcnt;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            bus.gnt    <= '0;
            bus.gnt_id <= '0;
            bus.active <= 1'b0;
            cnt        <= '0;
            ptr        <= IDW'(N_REQ - 1);
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
            tcnt            <= '0;
            bus.timeout_err <= 1'b0;
`endif
        end else begin
            bus.gnt <= '0;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
            bus.timeout_err <= 1'b0;
`endif
            case (state)
                IDLE: if (pick_valid) begin
                    state      <= WAIT_BUSY;
                    bus.gnt_id <= pick_idx;
                    bus.active <= 1'b1;
                    cnt        <= '0;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
                    tcnt       <= '0;
`endif
                end
                WAIT_BUSY: if (bus.busy) begin
                    cnt <= (cnt == CW'(BUSY_CNT)) ? cnt : cnt + 1'b1;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
                    tcnt <= '0;
`endif
                    // This sample is the BUSY_CNT-th one: grant shows up next cycle.
                    if (cnt == CW'(BUSY_CNT - 1)) begin
                        state   <= GRANT;
                        bus.gnt <= N_REQ'(1) << bus.gnt_id;
                    end
                end
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT_CYC - 1)) begin
                    // Stalled owner gives up priority just as if it had been granted.
                    state           <= IDLE;
                    bus.active      <= 1'b0;
                    bus.timeout_err <= 1'b1;
                    ptr             <= bus.gnt_id;
                end else
                    tcnt <= tcnt + 1'b1;
`endif
                GRANT: begin
                    state      <= IDLE;
                    bus.active <= 1'b0;
                    ptr        <= bus.gnt_id;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_busy_gnt_arbiter.sv
// tb_busy_gnt_arbiter: scoreboard bench for busy_gnt_arbiter with a transaction-level reference model
module tb_busy_gnt_arbiter;
    import busy_gnt_arb_pkg::*;
    localparam int N  = 4;
    localparam int BC = 3;
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
    localparam int TO = 16;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int got_log[$];
    int owner = -1;
    int seen = 0;
    int last = N - 1;
    int gap = 0;
    bit in_grant = 0;
    bit exp_terr = 0;
    logic [N-1:0] exp_g;
    logic [N-1:0] rnd;

    busy_gnt_arbiter_if #(.N_REQ(N)) bus ();
    busy_gnt_arbiter #(.N_REQ(N), .BUSY_CNT(BC)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic b);
        bus.req = r;
        bus.busy = b;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Reference model: one owner at a time, counts busy samples, pushes the owner on its grant cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner = -1; seen = 0; last = N - 1; gap = 0; in_grant = 0; exp_terr = 0;
            exp_q.delete();
        end else begin
            exp_terr = 0;
            if (in_grant) begin
                in_grant = 0; last = owner; owner = -1;
            end else if (owner < 0) begin
                for (int k = 1; k <= N; k++)
                    if (bus.req[(last + k) % N]) begin
                        owner = (last + k) % N; seen = 0; gap = 0;
                        break;
                    end
            end else if (bus.busy) begin
                seen++; gap = 0;
                if (seen == BC) begin
                    in_grant = 1;
                    exp_q.push_back(owner);
                end
            end
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
            else begin
                gap++;
                if (gap == TO) begin
                    exp_terr = 1; last = owner; owner = -1;
                end
            end
`endif
        end
    end

    // Monitor: pops expected grants whenever a grant is shown or one is due.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("active", {31'b0, bus.active}, {31'b0, owner >= 0});
            if (owner >= 0) chk("gnt_id", 32'(bus.gnt_id), owner);
            if (bus.gnt != '0 || exp_q.size() != 0) begin
                exp_g = '0;
                if (exp_q.size() != 0) exp_g = N'(1) << exp_q.pop_front();
                chk("gnt", 32'(bus.gnt), 32'(exp_g));
                for (int i = 0; i < N; i++) if (bus.gnt[i]) got_log.push_back(i);
            end
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
            chk("timeout_err", {31'b0, bus.timeout_err}, {31'b0, exp_terr});
`endif
        end
    end

    initial begin
        bus.req = '0;
        bus.busy = 1'b0;
        rnd = '0;
        repeat (2) @(negedge clk);
        chk("rst_active", {31'b0, bus.active}, 0);
        chk("rst_gnt", 32'(bus.gnt), 0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 0);
        rst_n = 1'b1;
        // single requester, continuous busy: minimum latency
        step(4'b0001, 1'b0);
        repeat (3) step(4'b0000, 1'b1);
        chk("t1_gnt", 32'(bus.gnt), 1);
        chk("t1_active", {31'b0, bus.active}, 1);
        step(4'b0000, 1'b0);
        chk("t1_gnt_off", 32'(bus.gnt), 0);
        step(4'b0000, 1'b0);
        // gapped busy; busy on the acceptance edge is ignored
        step(4'b0010, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        chk("t2_no_gnt", 32'(bus.gnt), 0);
        step(4'b0000, 1'b0);
        step(4'b0000, 1'b1);
        chk("t2_gnt", 32'(bus.gnt), 2);
        step(4'b0000, 1'b0);
        // all requesting, busy always: order 0,1,2,3,0
        do_reset();
        got_log.delete();
        repeat (25) step(4'b1111, 1'b1);
        repeat (2) step(4'b0000, 1'b0);
        chk("rr_count", got_log.size(), 5);
        for (int i = 0; i < 5; i++) chk("rr_order", (got_log.size() > i) ? got_log[i] : -1, i % 4);
        // async reset in WAIT_BUSY
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b0000, 1'b1);
        chk("ar_active_before", {31'b0, bus.active}, 1);
        chk("ar_id_before", 32'(bus.gnt_id), 3);
        rst_n = 1'b0;
        #1;
        chk("ar_active", {31'b0, bus.active}, 0);
        chk("ar_gnt", 32'(bus.gnt), 0);
        chk("ar_gnt_id", 32'(bus.gnt_id), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(4'b0100, 1'b0);
        repeat (3) step(4'b0000, 1'b1);
        chk("ar_gnt_after", 32'(bus.gnt), 4);
        step(4'b0000, 1'b0);
        // owner drops req right after acceptance
        step(4'b0001, 1'b0);
        repeat (3) step(4'b0000, 1'b1);
        chk("drop_gnt", 32'(bus.gnt), 1);
        step(4'b0000, 1'b0);
`ifdef BUSY_GNT_ARB_TIMEOUT_EN
        do_reset();
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b1);
        repeat (15) step(4'b0001, 1'b0);
        chk("to_not_yet", {31'b0, bus.timeout_err}, 0);
        step(4'b0001, 1'b0);
        chk("to_pulse", {31'b0, bus.timeout_err}, 1);
        chk("to_active", {31'b0, bus.active}, 0);
        chk("to_no_gnt", 32'(bus.gnt), 0);
        step(4'b0001, 1'b0);
        repeat (3) step(4'b0001, 1'b1);
        chk("to_next_gnt", 32'(bus.gnt), 1);
        step(4'b0000, 1'b0);
`endif
        // randomized traffic
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) rnd[b] = ~rnd[b];
            step(rnd, $urandom_range(0, 2) != 0);
        end
        repeat (10) step(4'b0000, 1'b1);
        chk("drain_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
